// File: rtl/pc_ctrl_if.sv
// Fetch PC controller bus: pipeline-side controls into the controller and the
// PC/exception status it reports back.
//  master : pipeline side (drives stall/redir/exc_req/eret, reads status)
//  slave  : pc_ctrl side (reads controls, drives pc/epc/exl/pend/adel)
interface pc_ctrl_if #(
   parameter int unsigned WIDTH = 32
);
   logic             stall;
   logic             redir;
   logic [WIDTH-1:0] redir_pc;
   logic             exc_req;
   logic [WIDTH-1:0] exc_pc;
   logic             eret;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] epc;
   logic             exl;
   logic             pend;
   logic             adel;

   modport master (
      output stall, redir, redir_pc, exc_req, exc_pc, eret,
      input  pc, epc, exl, pend, adel
   );

   modport slave (
      input  stall, redir, redir_pc, exc_req, exc_pc, eret,
      output pc, epc, exl, pend, adel
   );
endinterface

// File: rtl/pc_ctrl.sv
// Fetch-stage program-counter controller.
// Holds the fetch PC and picks the next one from exception entry, ERET,
// branch/jump redirect, a redirect buffered during a stall, or PC+STEP.
// Tracks EXL/EPC and flags misaligned or out-of-range fetch addresses.
//  clk   : clock, all state changes on rising edge
//  reset : synchronous active-high reset
//  bus   : pc_ctrl_if.slave (stall, redir, redir_pc, exc_req, exc_pc, eret
//          in; pc, epc, exl, pend registered out; adel combinational out)
module pc_ctrl #(
   parameter int unsigned      WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(32'h0000_3000),
   parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h0000_4180),
   parameter int unsigned      STEP       = 4,
   parameter logic [WIDTH-1:0] IMEM_LO    = WIDTH'(32'h0000_3000),
   parameter logic [WIDTH-1:0] IMEM_HI    = WIDTH'(32'h0000_4ffc)
) (
   input logic       clk,
   input logic       reset,
   pc_ctrl_if.slave  bus
);

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_HANDLER = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] epc_q;
   logic [WIDTH-1:0] pend_pc;
   logic             pend_q;

   // Next-PC selection and exception-level FSM, highest priority first.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_RUN;
         pc_q    <= RESET_PC;
         epc_q   <= '0;
         pend_q  <= 1'b0;
         pend_pc <= '0;
      end else if (bus.exc_req && (state == ST_RUN)) begin
         // Flush: taken regardless of stall; EPC is word-aligned.
         state  <= ST_HANDLER;
         pc_q   <= EXC_VECTOR;
         epc_q  <= bus.exc_pc & ~WIDTH'(3);
         pend_q <= 1'b0;
      end else if (bus.eret && (state == ST_HANDLER)) begin
         state  <= ST_RUN;
         pc_q   <= epc_q;
         pend_q <= 1'b0;
      end else if (bus.stall) begin
         // Hold PC; newest redirect replaces any older buffered one.
         if (bus.redir) begin
            pend_q  <= 1'b1;
            pend_pc <= bus.redir_pc;
         end
      end else if (bus.redir) begin
         pc_q   <= bus.redir_pc;
         pend_q <= 1'b0;
      end else if (pend_q) begin
         pc_q   <= pend_pc;
         pend_q <= 1'b0;
      end else begin
         pc_q <= pc_q + WIDTH'(STEP);
      end
   end

   assign bus.pc   = pc_q;
   assign bus.epc  = epc_q;
   assign bus.exl  = (state == ST_HANDLER);
   assign bus.pend = pend_q;

   // Address error report only; the pipeline decides whether to trap.
   assign bus.adel = (pc_q[1:0] != 2'b00) | (pc_q < IMEM_LO) | (pc_q > IMEM_HI);

endmodule
